// File: rtl/answer_pkg.sv
// Shared constants and types for the answer recorder and its keypad debouncer.
package answer_pkg;

    // Note word geometry as seen by the storage/playback block.
    localparam int NOTE_W = 4;
    localparam int SLOTS  = 8;
    localparam int IDX_W  = $clog2(SLOTS);

    // Note code 0 is a rest / no key pressed.
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMMIT  = 2'd2
    } rec_state_t;

    // Bit offset of slot k inside the packed note word.
    function automatic int slot_lsb(input int k);
        return NOTE_W * k;
    endfunction

endpackage

// File: rtl/note_debouncer.sv
// Keypad debouncer: settles the raw note code and emits a one-cycle press
// pulse when the settled level goes from rest to a key code.
module note_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int NOTE_W          = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note_in,
    output logic [NOTE_W-1:0] level,
    output logic              press,
    output logic [NOTE_W-1:0] press_code
);

    // Counter only needs to reach DEBOUNCE_CYCLES-1; the settle happens on
    // the edge after that, giving DEBOUNCE_CYCLES+1 stable samples in total
    // including the edge that captured the new code.
    localparam int            CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [NOTE_W-1:0] samp;
    logic [CW-1:0]     cnt;

    // Track the raw code, count stable cycles, and update the settled level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            samp       <= '0;
            cnt        <= '0;
            level      <= '0;
            press      <= 1'b0;
            press_code <= '0;
        end else begin
            press <= 1'b0;
            if (note_in != samp) begin
                // Any change restarts the stability window.
                samp <= note_in;
                cnt  <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CW'(1);
            end else if (level != samp) begin
                level <= samp;
                // Only a rest-to-key transition is a press; a direct key-to-key
                // change needs the level to pass through rest first.
                if (level == '0 && samp != '0) begin
                    press      <= 1'b1;
                    press_code <= samp;
                end
            end
        end
    end

endmodule

// File: rtl/answer_recorder.sv
// Records debounced keypad notes into a packed word and commits it to the
// answer storage block with a one-cycle write strobe.
module answer_recorder
    import answer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start_rec,
    input  logic                    stop_rec,
    input  logic [NOTE_W-1:0]       note_in,
    output logic [SLOTS*NOTE_W-1:0] data_out,
    output logic [3:0]              max_index,
    output logic                    write_enable,
    output logic                    recording,
    output logic [3:0]              count,
    output logic                    full
);

    localparam logic [3:0] SLOTS_C = 4'(SLOTS);

    rec_state_t              state, state_n;
    logic [SLOTS*NOTE_W-1:0] buffer, buf_n;
    logic [3:0]              count_n;
    logic                    commit;

    logic [NOTE_W-1:0]       key_level;
    logic                    press;
    logic [NOTE_W-1:0]       press_code;
    logic                    press_ok;

    note_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .NOTE_W         (NOTE_W)
    ) u_deb (
        .clk       (clk),
        .reset     (reset),
        .note_in   (note_in),
        .level     (key_level),
        .press     (press),
        .press_code(press_code)
    );

    // The pulse code always equals the freshly settled level; requiring both
    // keeps a stale code from ever being stored.
    assign press_ok = press && (key_level == press_code) && (press_code != NOTE_REST);

    // Next-state, buffer update and commit decision.
    always_comb begin
        state_n = state;
        buf_n   = buffer;
        count_n = count;
        commit  = 1'b0;
        case (state)
            IDLE: begin
                if (start_rec) begin
                    buf_n   = '0;
                    count_n = '0;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (start_rec) begin
                    // Restart wins over a coincident press.
                    buf_n   = '0;
                    count_n = '0;
                end else begin
                    // Store first so a coincident stop commits this note too.
                    if (press_ok && count != SLOTS_C) begin
                        buf_n[slot_lsb(int'(count[IDX_W-1:0])) +: NOTE_W] = press_code;
                        count_n = count + 4'd1;
                    end
                    if (count == SLOTS_C) begin
                        commit = 1'b1;
                    end else if (stop_rec) begin
                        if (count_n != 4'd0) commit  = 1'b1;
                        else                 state_n = IDLE;
                    end
                    if (commit) state_n = COMMIT;
                end
            end
            COMMIT: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, working buffer, and committed outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            buffer       <= '0;
            count        <= '0;
            data_out     <= '0;
            max_index    <= '0;
            write_enable <= 1'b0;
        end else begin
            state        <= state_n;
            buffer       <= buf_n;
            count        <= count_n;
            write_enable <= commit;
            // Committed word is loaded as the FSM enters COMMIT so it is valid
            // alongside the strobe, and held until the next commit.
            if (commit) begin
                data_out  <= buf_n;
                max_index <= count_n - 4'd1;
            end
        end
    end

    assign recording = (state == CAPTURE);
    assign full      = (count == SLOTS_C);

endmodule

// File: tb/tb_answer_recorder.sv
// Directed bench for answer_recorder with a short debounce window.
module tb_answer_recorder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_rec;
    logic        stop_rec;
    logic [3:0]  note_in;
    logic [31:0] data_out;
    logic [3:0]  max_index;
    logic        write_enable;
    logic        recording;
    logic [3:0]  count;
    logic        full;

    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int we_base;

    typedef struct {
        logic [3:0] code;
        logic [3:0] exp_count;
        logic       exp_full;
    } vec_t;

    vec_t vecs[10];

    answer_recorder #(.DEBOUNCE_CYCLES(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_rec   (start_rec),
        .stop_rec    (stop_rec),
        .note_in     (note_in),
        .data_out    (data_out),
        .max_index   (max_index),
        .write_enable(write_enable),
        .recording   (recording),
        .count       (count),
        .full        (full)
    );

    always #5 clk = ~clk;

    // Count strobe cycles mid-cycle, away from the active edge.
    always @(negedge clk) if (write_enable) we_cnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start_rec = 1'b1;
        tick();
        start_rec = 1'b0;
    endtask

    // Hold a key for 6 cycles then release for 6 cycles.
    task automatic press_note(input logic [3:0] code);
        note_in = code;
        repeat (6) tick();
        note_in = 4'd0;
        repeat (6) tick();
    endtask

    initial begin
        // Scenario 1 notes, then scenario 3 notes 1..7 (8th is hand-driven).
        vecs[0] = '{4'd3, 4'd1, 1'b0};
        vecs[1] = '{4'd5, 4'd2, 1'b0};
        vecs[2] = '{4'd7, 4'd3, 1'b0};
        for (int i = 0; i < 7; i++)
            vecs[3+i] = '{4'(i + 1), 4'(i + 1), 1'b0};

        reset = 1'b0; start_rec = 1'b0; stop_rec = 1'b0; note_in = 4'd0;
        repeat (3) tick();
        chk("rst_data", data_out, 32'h0);
        chk("rst_max", {28'h0, max_index}, 32'h0);
        chk("rst_we", {31'h0, write_enable}, 32'h0);
        chk("rst_rec", {31'h0, recording}, 32'h0);
        chk("rst_count", {28'h0, count}, 32'h0);
        chk("rst_full", {31'h0, full}, 32'h0);
        reset = 1'b1;
        tick();

        // 1. Basic recording
        pulse_start();
        chk("s1_recording", {31'h0, recording}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            press_note(vecs[i].code);
            chk($sformatf("s1_count%0d", i), {28'h0, count}, {28'h0, vecs[i].exp_count});
            chk($sformatf("s1_full%0d", i), {31'h0, full}, {31'h0, vecs[i].exp_full});
        end
        we_base = we_cnt;
        stop_rec = 1'b1;
        tick();
        stop_rec = 1'b0;
        chk("s1_we_latency", {31'h0, write_enable}, 32'h1);
        chk("s1_data", data_out, 32'h00000753);
        chk("s1_max", {28'h0, max_index}, 32'h2);
        repeat (3) tick();
        chk("s1_we_once", we_cnt - we_base, 1);
        chk("s1_idle", {31'h0, recording}, 32'h0);

        // 2. Bounce rejection
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            note_in = (i % 2 == 0) ? 4'd9 : 4'd0;
            repeat (2) tick();
        end
        chk("s2_bounce_count", {28'h0, count}, 32'h0);
        press_note(4'd9);
        chk("s2_count", {28'h0, count}, 32'h1);
        stop_rec = 1'b1;
        tick();
        stop_rec = 1'b0;
        chk("s2_data", data_out, 32'h00000009);
        tick();

        // 3. Auto-commit when full
        pulse_start();
        for (int i = 3; i < 10; i++) begin
            press_note(vecs[i].code);
            chk($sformatf("s3_count%0d", i - 2), {28'h0, count}, {28'h0, vecs[i].exp_count});
            chk($sformatf("s3_full%0d", i - 2), {31'h0, full}, {31'h0, vecs[i].exp_full});
        end
        we_base = we_cnt;
        note_in = 4'd8;
        repeat (6) tick();
        chk("s3_count8", {28'h0, count}, 32'h8);
        chk("s3_full8", {31'h0, full}, 32'h1);
        chk("s3_we_early", {31'h0, write_enable}, 32'h0);
        tick();
        chk("s3_we_auto", {31'h0, write_enable}, 32'h1);
        chk("s3_data", data_out, 32'h87654321);
        chk("s3_max", {28'h0, max_index}, 32'h7);
        note_in = 4'd0;
        repeat (6) tick();
        press_note(4'd9);
        chk("s3_9th_count", {28'h0, count}, 32'h8);
        chk("s3_9th_data", data_out, 32'h87654321);
        chk("s3_we_once", we_cnt - we_base, 1);

        // 4. Empty stop
        we_base = we_cnt;
        pulse_start();
        chk("s4_count_clear", {28'h0, count}, 32'h0);
        stop_rec = 1'b1;
        tick();
        stop_rec = 1'b0;
        repeat (2) tick();
        chk("s4_no_we", we_cnt - we_base, 0);
        chk("s4_idle", {31'h0, recording}, 32'h0);
        chk("s4_data_kept", data_out, 32'h87654321);
        chk("s4_max_kept", {28'h0, max_index}, 32'h7);

        // 5. Stop coincides with the debounced press of note 6
        pulse_start();
        press_note(4'd2);
        press_note(4'd4);
        we_base = we_cnt;
        note_in = 4'd6;
        repeat (5) tick();
        stop_rec = 1'b1;
        tick();
        stop_rec = 1'b0;
        chk("s5_we", {31'h0, write_enable}, 32'h1);
        chk("s5_data", data_out, 32'h00000642);
        chk("s5_max", {28'h0, max_index}, 32'h2);
        note_in = 4'd0;
        repeat (6) tick();
        chk("s5_we_once", we_cnt - we_base, 1);

        // 6. Reset mid-recording
        pulse_start();
        press_note(4'd1);
        press_note(4'd2);
        chk("s6_count_pre", {28'h0, count}, 32'h2);
        we_base = we_cnt;
        #2 reset = 1'b0;
        #1;
        chk("s6_rst_data", data_out, 32'h0);
        chk("s6_rst_max", {28'h0, max_index}, 32'h0);
        chk("s6_rst_count", {28'h0, count}, 32'h0);
        chk("s6_rst_rec", {31'h0, recording}, 32'h0);
        chk("s6_rst_we", {31'h0, write_enable}, 32'h0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (2) tick();
        chk("s6_no_we", we_cnt - we_base, 0);
        pulse_start();
        press_note(4'd5);
        stop_rec = 1'b1;
        tick();
        stop_rec = 1'b0;
        chk("s6_new_we", {31'h0, write_enable}, 32'h1);
        chk("s6_new_data", data_out, 32'h00000005);
        chk("s6_new_max", {28'h0, max_index}, 32'h0);
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
